// File: rtl/axi_pkg.sv
// Shared AXI-lite constants and FSM state types.
// Imported by the slave memory top and its register file.
package axi_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_COLLECT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_slv_regfile.sv
// DEPTH x 32 register array: sync write, registered read, sync clear.
// Ports: clk/rst, write (we_i, widx_i, wdata_i), read (re_i, rhit_i, ridx_i, rdata_o).
module axi_slv_regfile
  import axi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [AXI_DATA_W-1:0] wdata_i,
  input  logic                  re_i,
  input  logic                  rhit_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [AXI_DATA_W-1:0] rdata_o
);

  logic [AXI_DATA_W-1:0] mem_q [DEPTH];
  logic [AXI_DATA_W-1:0] rdata_q;

  // Non-blocking update gives the old word on a same-edge write/read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[widx_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= rhit_i ? mem_q[ridx_i] : '0;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI-lite slave with a word-addressed DEPTH x 32 memory.
// Ports: AW/W/B write channel, AR/R read channel, clk and sync rst.
module axi_lite_slave_mem
  import axi_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [AXI_ADDR_W-1:0] aw_addr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [AXI_DATA_W-1:0] w_data,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [AXI_ADDR_W-1:0] ar_addr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [AXI_DATA_W-1:0] r_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [AXI_ADDR_W-1:0] SPAN =
    AXI_ADDR_W'(DEPTH * 4);

  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [AXI_ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_commit;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  ar_hs;

  logic [AXI_ADDR_W-1:0] aw_off, ar_off;
  logic                  aw_ok, ar_ok;

  // Offset wraps modulo 2^32, so addresses below the base fail the range test.
  assign aw_off = aw_addr_q - BASE_ADDR;
  assign ar_off = ar_addr - BASE_ADDR;
  assign aw_ok  = (aw_off < SPAN) && (aw_addr_q[1:0] == 2'b00);
  assign ar_ok  = (ar_off < SPAN) && (ar_addr[1:0] == 2'b00);

  assign awready = (wr_state_q == WR_COLLECT) && !aw_held_q;
  assign wready  = (wr_state_q == WR_COLLECT) && !w_held_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      WR_COLLECT: begin
        if (aw_held_q && w_held_q) begin
          wr_commit  = 1'b1;
          bvalid_d   = 1'b1;
          bresp_d    = aw_ok ? RESP_OKAY : RESP_SLVERR;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_RESP;
        end else begin
          if (awvalid && !aw_held_q) begin
            aw_addr_d = aw_addr;
            aw_held_d = 1'b1;
          end
          if (wvalid && !w_held_q) begin
            w_data_d = w_data;
            w_held_d = 1'b1;
          end
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_COLLECT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  assign arready = (rd_state_q == RD_IDLE);
  assign rvalid  = (rd_state_q == RD_DATA);
  assign ar_hs   = arvalid && arready;

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RD_IDLE: if (arvalid) rd_state_d = RD_DATA;
      RD_DATA: if (rready)  rd_state_d = RD_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  axi_slv_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_commit && aw_ok),
    .widx_i  (aw_off[2 +: IDX_W]),
    .wdata_i (w_data_q),
    .re_i    (ar_hs),
    .rhit_i  (ar_ok),
    .ridx_i  (ar_off[2 +: IDX_W]),
    .rdata_o (r_data)
  );

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed plus randomized bench for axi_lite_slave_mem.
// Reference memory is a plain array updated from the decode rules.
module tb_axi_lite_slave_mem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [31:0] aw_addr;
  logic        wvalid, wready;
  logic [31:0] w_data;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] ar_addr;
  logic        rvalid, rready;
  logic [31:0] r_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  axi_lite_slave_mem #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .awvalid (awvalid),
    .awready (awready),
    .aw_addr (aw_addr),
    .wvalid  (wvalid),
    .wready  (wready),
    .w_data  (w_data),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .arvalid (arvalid),
    .arready (arready),
    .ar_addr (ar_addr),
    .rvalid  (rvalid),
    .rready  (rready),
    .r_data  (r_data)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_ok(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) / 4 < DEPTH) && (a % 4 == 0);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return m_ok(a) ? model[m_idx(a)] : 32'h0;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input int aw_dly, input int w_dly, input int b_dly);
    int t = 0;
    bit awd = 0, wd = 0, haw, hw;
    logic [1:0] er;
    er = m_ok(a) ? 2'b00 : 2'b10;
    aw_addr = a;
    w_data  = d;
    bready  = 0;
    while (!(awd && wd)) begin
      if (t > 40) begin
        awvalid = 0;
        wvalid  = 0;
        timeout("wr_handshake");
        return;
      end
      awvalid = !awd && (t >= aw_dly);
      wvalid  = !wd && (t >= w_dly);
      haw = awvalid && awready;
      hw  = wvalid && wready;
      step();
      if (haw) awd = 1;
      if (hw) wd = 1;
      t++;
    end
    awvalid = 0;
    wvalid  = 0;
    chk("wr_bvalid_n1", 32'(bvalid), 32'd0);
    chk("wr_awready_n1", 32'(awready), 32'd0);
    step();
    if (m_ok(a)) model[m_idx(a)] = d;
    for (int i = 0; i <= b_dly; i++) begin
      chk("wr_bvalid", 32'(bvalid), 32'd1);
      chk("wr_bresp", 32'(bresp), 32'(er));
      chk("wr_awready_busy", 32'(awready), 32'd0);
      chk("wr_wready_busy", 32'(wready), 32'd0);
      if (i == b_dly) bready = 1;
      step();
    end
    bready = 0;
    chk("wr_bvalid_drop", 32'(bvalid), 32'd0);
    chk("wr_awready_back", 32'(awready), 32'd1);
    chk("wr_wready_back", 32'(wready), 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input int r_dly);
    int t = 0;
    bit hs = 0;
    logic [31:0] exp;
    ar_addr = a;
    rready  = 0;
    while (!hs) begin
      if (t > 40) begin
        arvalid = 0;
        timeout("rd_handshake");
        return;
      end
      arvalid = 1;
      hs = arready;
      exp = m_rd(a);
      step();
      t++;
    end
    arvalid = 0;
    for (int i = 0; i <= r_dly; i++) begin
      chk("rd_rvalid", 32'(rvalid), 32'd1);
      chk("rd_data", r_data, exp);
      chk("rd_arready_busy", 32'(arready), 32'd0);
      if (i == r_dly) rready = 1;
      step();
    end
    rready = 0;
    chk("rd_rvalid_drop", 32'(rvalid), 32'd0);
    chk("rd_arready_back", 32'(arready), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 5);
    if (k <= 3) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    if (k == 4) return BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
    return BASE + 32'(4 * $urandom_range(0, DEPTH - 1))
         + 32'($urandom_range(1, 3));
  endfunction

  initial begin
    rst = 1; awvalid = 0; wvalid = 0; bready = 0;
    arvalid = 0; rready = 0;
    aw_addr = 0; ar_addr = 0; w_data = 0;
    foreach (model[i]) model[i] = 32'h0;

    step();
    step();
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rdata", r_data, 32'd0);
    rst = 0;
    step();

    rd(32'h0, 0);

    wr(32'h8, 32'hDEAD_BEEF, 0, 0, 0);
    rd(32'h8, 0);

    wr(32'hC, 32'h0000_1234, 4, 0, 4);
    rd(32'hC, 2);

    wr(32'h40, 32'hFFFF_FFFF, 0, 0, 1);
    wr(32'h6, 32'hFFFF_FFFF, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) rd(BASE + 32'(4 * i), 0);
    rd(32'h40, 0);

    wr(32'h4, 32'h0000_000A, 0, 0, 0);
    aw_addr = 32'h4; w_data = 32'h0000_000B;
    awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    ar_addr = 32'h4; arvalid = 1;
    chk("col_arready", 32'(arready), 32'd1);
    step();
    arvalid = 0;
    chk("col_rvalid", 32'(rvalid), 32'd1);
    chk("col_rdata_old", r_data, 32'h0000_000A);
    chk("col_bvalid", 32'(bvalid), 32'd1);
    chk("col_bresp", 32'(bresp), 32'd0);
    model[1] = 32'h0000_000B;
    rready = 1; bready = 1;
    step();
    rready = 0; bready = 0;
    chk("col_rvalid_drop", 32'(rvalid), 32'd0);
    chk("col_bvalid_drop", 32'(bvalid), 32'd0);
    rd(32'h4, 0);

    ar_addr = 32'h8; arvalid = 1;
    aw_addr = 32'hC; w_data = 32'h5555_5555;
    awvalid = 1; wvalid = 1;
    step();
    arvalid = 0; awvalid = 0; wvalid = 0;
    chk("mrst_rvalid_pre", 32'(rvalid), 32'd1);
    chk("mrst_rdata_pre", r_data, 32'hDEAD_BEEF);
    rst = 1;
    step();
    rst = 0;
    foreach (model[i]) model[i] = 32'h0;
    chk("mrst_rvalid", 32'(rvalid), 32'd0);
    chk("mrst_bvalid", 32'(bvalid), 32'd0);
    chk("mrst_rdata", r_data, 32'd0);
    chk("mrst_awready", 32'(awready), 32'd1);
    chk("mrst_arready", 32'(arready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mrst_no_late_b", 32'(bvalid), 32'd0);
      step();
    end
    for (int i = 0; i < DEPTH; i++) rd(BASE + 32'(4 * i), 0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        wr(rand_addr(), $urandom,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)));
      end else begin
        rd(rand_addr(), int'($urandom_range(0, 3)));
      end
    end
    for (int i = 0; i < DEPTH; i++) rd(BASE + 32'(4 * i), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI-lite style responder (slave) that sits on the dut side of the team's AXI interface and is driven by the testbench master.
- Provides a word-addressed register memory of DEPTH x 32-bit entries.
- Accepts independent AW/W/B write traffic and AR/R read traffic with registered responses; reports write errors on bresp.
- Serves as the golden DUT for bring-up of the AXI agent/scoreboard.

Parameters:
DEPTH, 16, number of 32-bit words; power of two, 2..1024
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*4

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
awvalid  input  1  write address valid
awready  output  1  write address ready
aw_addr  input  32  write byte address
wvalid  input  1  write data valid
wready  output  1  write data ready
w_data  input  32  write data (full word; no strobes)
bvalid  output  1  write response valid
bready  input  1  write response ready
bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
arvalid  input  1  read address valid
arready  output  1  read address ready
ar_addr  input  32  read byte address
rvalid  output  1  read data valid
rready  input  1  read data ready
r_data  output  32  read data

Behaviour:
- Reset (rst=1 at a rising edge): all memory words = 0, bvalid=0, bresp=2'b00, rvalid=0, r_data=0, awready=1, wready=1, arready=1, and all hold flags are cleared. Reset mid-transaction drops any pending response with no write commit.
- Address decode: offset = addr - BASE_ADDR.
  - Valid iff offset < DEPTH*4 and addr[1:0] == 2'b00.
  - index = offset[2 +: $clog2(DEPTH)].
- Write FSM states: WR_COLLECT, WR_RESP.
  - WR_COLLECT:
    - awready = !aw_held; wready = !w_held.
    - An AW handshake latches aw_addr and sets aw_held. A W handshake latches w_data and sets w_held.
    - AW and W may arrive in either order or in the same cycle; extra valids are back-pressured.
    - In a cycle where aw_held && w_held: on that edge, if the address is valid, mem[index] <= data and bresp <= OKAY; otherwise there is no write and bresp <= SLVERR. Also bvalid <= 1, holds clear, and the FSM goes to WR_RESP.
    - Latency: if the later of the AW/W handshakes is in cycle N, the memory updates at the end of N+1 and bvalid is high from cycle N+2.
  - WR_RESP:
    - awready = 0, wready = 0.
    - bvalid and bresp are held stable until bready=1. On that edge bvalid <= 0 and the FSM returns to WR_COLLECT, so awready/wready are high in the next cycle.
- Read FSM states: RD_IDLE, RD_DATA.
  - RD_IDLE: arready = 1. An arvalid handshake in cycle N registers r_data = mem[index] (or 32'h0 if the address is invalid) and sets rvalid = 1 from cycle N+1.
  - RD_DATA:
    - arready = 0.
    - rvalid and r_data are held stable until rready=1. On that edge rvalid <= 0 and the FSM returns to RD_IDLE; a new AR is accepted no earlier than the following cycle.
- Read and write paths are fully independent and may both be active in any cycle.
- A write commit and an AR handshake to the same word on the same edge: the read returns the OLD value.
- Ready signals never depend combinationally on valid. valid-to-ready has no combinational path; all outputs are registered or decoded from state/hold flags only.
- A master dropping valid before the handshake is a protocol violation; this block does not check for it.

Decomposition:
- Package axi_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - typedef enum wr_state_t {WR_COLLECT, WR_RESP}.
  - typedef enum rd_state_t {RD_IDLE, RD_DATA}.
  - AXI_DATA_W = 32, AXI_ADDR_W = 32.
- One sub-module, axi_slv_regfile: DEPTH x 32 array with a synchronous write port, a registered read port, synchronous clear on rst, and read-old-on-collision semantics.
- Top level holds both FSMs, address decode and the hold registers.

Test Plan:
- Reset then AR 0x0 with rready=1 -> rvalid high 1 cycle after the handshake, r_data=0. Outputs during reset: awready=wready=arready=1, bvalid=rvalid=0.
- AW 0x8 and W 0xDEADBEEF in the same cycle N, bready=1 -> bvalid in N+2 with bresp=00; then AR 0x8 -> r_data=0xDEADBEEF.
- W 0x1234 at cycle 3, AW 0xC at cycle 7, bready held 0 for 4 cycles -> bvalid from cycle 9, stable 4 cycles, awready=wready=0 throughout; read 0xC = 0x1234.
- AW 0x40 (DEPTH=16, out of range) and AW 0x6 (misaligned) with data 0xFFFF_FFFF -> bresp=2'b10 both times; all words unchanged; AR 0x40 -> r_data=0.
- Write 0xA to 0x4, then commit 0xB to 0x4 on the same edge as an AR 0x4 handshake -> r_data=0xA; a subsequent read returns 0xB.
- rvalid held with rready=0 while rst pulses for 1 cycle -> rvalid=0, bvalid=0 and memory zeroed after the reset edge; no late bvalid appears.
